// File: rtl/pipeline_arb_buffered.sv
// pipeline_arb_buffered: valid-tagged pipeline feeding an output FIFO that arbitrates for a shared combinational resource
module pipeline_arb_buffered #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              inputs,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               flush,
    output logic [DATA_WIDTH-1:0]              outputs,
    output logic                               out_valid,
    output logic                               arbiter_req,
    input  logic                               arbiter_grant,
    output logic [DATA_WIDTH-1:0]              resource_input,
    input  logic [DATA_WIDTH-1:0]              resource_output,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy,
    output logic [CNT_WIDTH-1:0]               stall_count
);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int AW = $clog2(BUF_DEPTH);
    logic [DATA_WIDTH-1:0] sd_q [STAGES];
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [STAGES-1:0]     sv_q, sv_d;
    logic [AW-1:0]         wp_q, rp_q;
    logic [OW-1:0]         occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  ov_q, pop, stall, accept, wr;
    always_comb begin
        arbiter_req    = occ_q != '0 && !flush;
        pop            = arbiter_req && arbiter_grant;
        stall          = sv_q[STAGES-1] && occ_q == OW'(BUF_DEPTH) && !pop;
        in_ready       = !stall && !flush;
        accept         = in_valid && in_ready;
        wr             = sv_q[STAGES-1] && !stall;
        sv_d           = STAGES'({sv_q, accept});
        occ_d          = occ_q + OW'(wr) - OW'(pop);
        resource_input = occ_q == '0 ? '0 : mem_q[rp_q];
        occupancy      = occ_q;
        stall_count    = cnt_q;
        outputs        = out_q;
        out_valid      = ov_q;
    end
    always_ff @(posedge clk) begin
        if (!stall) begin
            sd_q[0] <= inputs;
            for (int i = 1; i < STAGES; i++) sd_q[i] <= sd_q[i-1];
        end
        if (wr) mem_q[wp_q] <= sd_q[STAGES-1];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sv_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            ov_q <= pop;
            if (pop) out_q <= resource_output;
            if (stall && !flush && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (flush) begin
                sv_q  <= '0;
                wp_q  <= '0;
                rp_q  <= '0;
                occ_q <= '0;
            end else begin
                if (!stall) sv_q <= sv_d;
                if (wr) wp_q <= wp_q + 1'b1;
                if (pop) rp_q <= rp_q + 1'b1;
                occ_q <= occ_d;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_arb_buffered.sv
// tb_pipeline_arb_buffered: directed scenario checks; the resource returns data+1
module tb_pipeline_arb_buffered;
    logic        clk = 1'b0;
    logic        reset, in_valid, flush, arbiter_grant;
    logic [31:0] inputs;
    logic [31:0] outputs, resource_input, resource_output;
    logic        out_valid, in_ready, arbiter_req;
    logic [2:0]  occupancy;
    logic [15:0] stall_count;
    logic [31:0] outputs4, resource_input4, resource_output4;
    logic        out_valid4, in_ready4, arbiter_req4;
    logic [2:0]  occupancy4;
    logic [3:0]  stall_count4;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;
    assign resource_output  = resource_input + 32'd1;
    assign resource_output4 = resource_input4 + 32'd1;

    pipeline_arb_buffered #(.DATA_WIDTH(32), .STAGES(2), .BUF_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .inputs(inputs), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .outputs(outputs), .out_valid(out_valid), .arbiter_req(arbiter_req),
        .arbiter_grant(arbiter_grant), .resource_input(resource_input),
        .resource_output(resource_output), .occupancy(occupancy), .stall_count(stall_count));

    pipeline_arb_buffered #(.DATA_WIDTH(32), .STAGES(2), .BUF_DEPTH(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .inputs(inputs), .in_valid(in_valid), .in_ready(in_ready4),
        .flush(flush), .outputs(outputs4), .out_valid(out_valid4), .arbiter_req(arbiter_req4),
        .arbiter_grant(arbiter_grant), .resource_input(resource_input4),
        .resource_output(resource_output4), .occupancy(occupancy4), .stall_count(stall_count4));

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; inputs = '0; flush = 1'b0; arbiter_grant = 1'b0;
        cyc; cyc;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        checks++; if (outputs !== 32'h0) begin fails++; $display("FAIL reset_outputs got %0h want 0", outputs); end
        checks++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (stall_count !== 16'd0) begin fails++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
        checks++; if (arbiter_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0h want 0", arbiter_req); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
        checks++; if (resource_input !== 32'h0) begin fails++; $display("FAIL reset_resource_input got %0h want 0", resource_input); end
    endtask

    task automatic test_latency;
        do_reset;
        arbiter_grant = 1'b1; in_valid = 1'b1; inputs = 32'h11;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_in_ready got %0h want 1", in_ready); end
        cyc;
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            checks++; if (arbiter_req !== (c == 3)) begin fails++; $display("FAIL lat_req c=%0d got %0h want %0h", c, arbiter_req, c == 3); end
            checks++; if (out_valid !== (c == 4)) begin fails++; $display("FAIL lat_out_valid c=%0d got %0h want %0h", c, out_valid, c == 4); end
            if (c == 3) begin
                checks++; if (resource_input !== 32'h11) begin fails++; $display("FAIL lat_resource_input got %0h want 11", resource_input); end
            end
            if (c == 4) begin
                checks++; if (outputs !== 32'h12) begin fails++; $display("FAIL lat_outputs got %0h want 12", outputs); end
            end
            cyc;
        end
    endtask

    task automatic test_backpressure;
        int idx = 0, exp = 0;
        do_reset;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; inputs = 32'(idx + 1);
            #1;
            if (in_ready) idx++;
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_output c=%0d got %0h want 0", c, out_valid); end
            cyc;
        end
        #1;
        checks++; if (idx != 6) begin fails++; $display("FAIL bp_accepts got %0d want 6", idx); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0h want 0", in_ready); end
        checks++; if (occupancy !== 3'd4) begin fails++; $display("FAIL bp_occupancy got %0d want 4", occupancy); end
        checks++; if (stall_count !== 16'd4) begin fails++; $display("FAIL bp_stall_count got %0d want 4", stall_count); end
        arbiter_grant = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = idx < 10; inputs = 32'(idx + 1);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                checks++; if (outputs !== 32'(exp + 2)) begin fails++; $display("FAIL bp_order got %0h want %0h", outputs, exp + 2); end
                exp++;
            end else if (exp > 0 && exp < 10) begin
                checks++; fails++; $display("FAIL bp_gap got out_valid 0 want 1 after %0d results", exp);
            end
            cyc;
        end
        checks++; if (exp != 10) begin fails++; $display("FAIL bp_result_count got %0d want 10", exp); end
        checks++; if (occupancy !== 3'd0) begin fails++; $display("FAIL bp_drained got %0d want 0", occupancy); end
        checks++; if (stall_count !== 16'd4) begin fails++; $display("FAIL bp_stall_final got %0d want 4", stall_count); end
    endtask

    task automatic test_back_to_back;
        int idx = 0, exp = 0;
        do_reset;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1; inputs = 32'h20 + 32'(idx);
            #1;
            if (in_ready) idx++;
            cyc;
        end
        arbiter_grant = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = idx < 12; inputs = 32'h20 + 32'(idx);
            #1;
            if (in_valid) begin
                checks++; if (occupancy !== 3'd4) begin fails++; $display("FAIL b2b_occupancy got %0d want 4", occupancy); end
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %0h want 1", in_ready); end
                checks++; if (stall_count !== 16'd1) begin fails++; $display("FAIL b2b_stall_count got %0d want 1", stall_count); end
                if (in_ready) idx++;
            end
            if (out_valid) begin
                checks++; if (outputs !== 32'h21 + 32'(exp)) begin fails++; $display("FAIL b2b_order got %0h want %0h", outputs, 32'h21 + exp); end
                exp++;
            end
            cyc;
        end
        checks++; if (exp != 12) begin fails++; $display("FAIL b2b_result_count got %0d want 12", exp); end
    endtask

    task automatic test_flush;
        do_reset;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; inputs = 32'h51 + 32'(c);
            cyc;
        end
        #1;
        checks++; if (occupancy !== 3'd3) begin fails++; $display("FAIL fl_pre_occupancy got %0d want 3", occupancy); end
        flush = 1'b1; inputs = 32'h99; arbiter_grant = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fl_in_ready got %0h want 0", in_ready); end
        checks++; if (arbiter_req !== 1'b0) begin fails++; $display("FAIL fl_req got %0h want 0", arbiter_req); end
        cyc;
        flush = 1'b0; inputs = 32'hAA;
        #1;
        checks++; if (occupancy !== 3'd0) begin fails++; $display("FAIL fl_occupancy got %0d want 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_out_valid got %0h want 0", out_valid); end
        cyc;
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            checks++; if (out_valid !== (c == 4)) begin fails++; $display("FAIL fl_after c=%0d got %0h want %0h", c, out_valid, c == 4); end
            if (c == 4) begin
                checks++; if (outputs !== 32'hAB) begin fails++; $display("FAIL fl_outputs got %0h want ab", outputs); end
            end
            cyc;
        end
    endtask

    task automatic test_grant;
        int idx = 0, exp = 0;
        do_reset;
        arbiter_grant = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gr_idle_out_valid got %0h want 0", out_valid); end
            checks++; if (occupancy !== 3'd0) begin fails++; $display("FAIL gr_idle_occupancy got %0d want 0", occupancy); end
            cyc;
        end
        for (int c = 0; c < 30; c++) begin
            arbiter_grant = (c % 2) == 1; in_valid = idx < 4; inputs = 32'h40 + 32'(idx);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                checks++; if (outputs !== 32'h41 + 32'(exp)) begin fails++; $display("FAIL gr_order got %0h want %0h", outputs, 32'h41 + exp); end
                exp++;
            end
            cyc;
        end
        checks++; if (exp != 4) begin fails++; $display("FAIL gr_result_count got %0d want 4", exp); end
    endtask

    task automatic test_reset_saturation;
        int idx = 0;
        do_reset;
        for (int c = 0; c < 26; c++) begin
            in_valid = 1'b1; inputs = 32'h61 + 32'(idx);
            #1;
            if (in_ready) idx++;
            if (c == 16) begin
                checks++; if (stall_count4 !== 4'd10) begin fails++; $display("FAIL sat_mid4 got %0d want 10", stall_count4); end
            end
            if (c == 21) begin
                checks++; if (stall_count4 !== 4'd15) begin fails++; $display("FAIL sat_at15 got %0d want 15", stall_count4); end
            end
            cyc;
        end
        #1;
        checks++; if (stall_count4 !== 4'd15) begin fails++; $display("FAIL sat_hold got %0d want 15", stall_count4); end
        checks++; if (stall_count !== 16'd20) begin fails++; $display("FAIL sat_wide got %0d want 20", stall_count); end
        in_valid = 1'b0; arbiter_grant = 1'b1;
        cyc; cyc; cyc;
        arbiter_grant = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rst_pre_occupancy got %0d want 3", occupancy); end
        checks++; if (outputs !== 32'h64) begin fails++; $display("FAIL rst_pre_outputs got %0h want 64", outputs); end
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        #1;
        checks++; if (outputs !== 32'h0) begin fails++; $display("FAIL rst_outputs got %0h want 0", outputs); end
        checks++; if (occupancy !== 3'd0) begin fails++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
        checks++; if (stall_count !== 16'd0) begin fails++; $display("FAIL rst_stall_count got %0d want 0", stall_count); end
        checks++; if (stall_count4 !== 4'd0) begin fails++; $display("FAIL rst_stall_count4 got %0d want 0", stall_count4); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
        arbiter_grant = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_no_output c=%0d got %0h want 0", c, out_valid); end
            cyc;
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_backpressure;
        test_back_to_back;
        test_flush;
        test_grant;
        test_reset_saturation;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
